// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: issue/result handshake bundle between a dispatcher and muldiv_unit
interface muldiv_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;
  modport master (
    output in_valid, funct3, rs1_data, rs2_data, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
  modport slave (
    input  in_valid, funct3, rs1_data, rs2_data, in_tag, flush, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV-M unit, radix-8 Booth multiplier plus optional radix-2 divider.
// Define MULDIV_DIV_EN to build the divider; without it funct3 1xx completes in one cycle with 0.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 3
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int ITER_M = (XLEN + 3) / 3;
  localparam int MB     = 3 * ITER_M;
  localparam int PW     = 2 * XLEN;
  localparam int CW     = $clog2(XLEN + 1);
`ifdef MULDIV_DIV_EN
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, MUL, DONE} state_t;
`endif
  state_t           state, nxt;
  logic [2:0]       op;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    acc, mcand, m3, ext1, mult, pp, acc_nxt;
  logic [MB:0]      mreg;
  logic [3:0]       dig, mag;
  logic [XLEN-1:0]  out_data, init_data;
  logic [TAG_W-1:0] out_tag;
  logic             accept, ext2, special;
  assign accept        = state == IDLE && bus.in_valid && !bus.flush;
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.out_data  = out_data;
  assign bus.out_tag   = out_tag;
  // rs1 is unsigned only for MULHU; rs2 is signed only for MUL and MULH
  assign ext1 = {{XLEN{bus.funct3 != 3'b011 && bus.rs1_data[XLEN-1]}}, bus.rs1_data};
  assign ext2 = !bus.funct3[1] && bus.rs2_data[XLEN-1];
  // Booth digit from the low 4 bits of the shifting multiplier, then the signed multiple
  always_comb begin
    dig     = 4'({mreg[2], 1'b0}) + 4'(mreg[1]) + 4'(mreg[0]) - 4'({mreg[3], 2'b00});
    mag     = dig[3] ? -dig : dig;
    mult    = mag == 4'd1 ? mcand : mag == 4'd2 ? mcand << 1 : mag == 4'd3 ? m3 :
              mag == 4'd4 ? mcand << 2 : '0;
    pp      = dig[3] ? -mult : mult;
    acc_nxt = acc + pp;
  end
`ifdef MULDIV_DIV_EN
  logic            sgn, n1, n2, div0, ovf, ge, q_neg, r_neg;
  logic [XLEN-1:0] a1, a2, diff, quo, rem, fix_res;
  logic [XLEN:0]   sh;
  // operand magnitudes, special-case detection and restoring-division step
  always_comb begin
    sgn       = !bus.funct3[0];
    n1        = sgn && bus.rs1_data[XLEN-1];
    n2        = sgn && bus.rs2_data[XLEN-1];
    a1        = n1 ? -bus.rs1_data : bus.rs1_data;
    a2        = n2 ? -bus.rs2_data : bus.rs2_data;
    div0      = bus.rs2_data == '0;
    ovf       = sgn && bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}} && &bus.rs2_data;
    special   = div0 || ovf;
    init_data = !bus.funct3[2] ? '0 :
                div0 ? (bus.funct3[1] ? bus.rs1_data : '1) :
                ovf  ? (bus.funct3[1] ? '0 : bus.rs1_data) : '0;
    sh        = acc[PW-1:XLEN-1];
    ge        = sh >= {1'b0, mcand[XLEN-1:0]};
    diff      = sh[XLEN-1:0] - mcand[XLEN-1:0];
    quo       = acc[XLEN-1:0];
    rem       = acc[PW-1:XLEN];
    fix_res   = op[1] ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo);
  end
`else
  assign special   = 1'b1;
  assign init_data = '0;
`endif
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end
  // next state; flush overrides acceptance and completion
  always_comb begin
    nxt = state;
    case (state)
`ifdef MULDIV_DIV_EN
      IDLE: if (accept) nxt = !bus.funct3[2] ? MUL : special ? DONE : DIV;
      DIV:  if (cnt == CW'(XLEN - 1)) nxt = FIX;
      FIX:  nxt = DONE;
`else
      IDLE: if (accept) nxt = bus.funct3[2] && special ? DONE : MUL;
`endif
      MUL:  if (cnt == CW'(ITER_M - 1)) nxt = DONE;
      DONE: if (bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (bus.flush) nxt = IDLE;
  end
  // operand capture, iteration datapath and registered result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op       <= '0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      m3       <= '0;
      mreg     <= '0;
      out_data <= '0;
      out_tag  <= '0;
`ifdef MULDIV_DIV_EN
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
`endif
    end else if (accept) begin
      op       <= bus.funct3;
      out_tag  <= bus.in_tag;
      out_data <= init_data;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= ext1;
      m3       <= ext1 + (ext1 << 1);
      mreg     <= {{(MB - XLEN){ext2}}, bus.rs2_data, 1'b0};
`ifdef MULDIV_DIV_EN
      q_neg    <= n1 ^ n2;
      r_neg    <= n1;
      if (bus.funct3[2]) begin
        acc   <= PW'(a1);
        mcand <= PW'(a2);
      end
`endif
    end else if (state == MUL) begin
      acc   <= acc_nxt;
      mcand <= mcand << 3;
      m3    <= m3 << 3;
      mreg  <= mreg >> 3;
      cnt   <= cnt + 1'b1;
      if (cnt == CW'(ITER_M - 1)) out_data <= op == 3'b000 ? acc_nxt[XLEN-1:0] : acc_nxt[PW-1:XLEN];
    end
`ifdef MULDIV_DIV_EN
    else if (state == DIV) begin
      acc <= {ge ? diff : sh[XLEN-1:0], acc[XLEN-2:0], ge};
      cnt <= cnt + 1'b1;
    end else if (state == FIX) begin
      out_data <= fix_res;
    end
`endif
  end
endmodule
